// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg
//   Shared types and constants for the register-file access controller.
//   - state_e    : controller FSM state (IDLE serves requests, FLUSH zeroes the file)
//   - REQ_LOADER : requester index of the matrix loader
//   - REQ_ROT    : requester index of the rotation unit
package rf_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic REQ_LOADER = 1'b0;
  localparam logic REQ_ROT    = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-input round-robin arbiter, purely combinational.
//   Ports:
//     req_i [1:0] : request vector
//     ptr_i       : priority pointer, 0 = requester 0 wins a tie, 1 = requester 1 wins
//     en_i        : arbitration enable; no grant is issued when low
//     gnt_o [1:0] : one-hot grant (all zero when disabled or idle)
module rr_arb2
  import rf_ctrl_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = (ptr_i == REQ_ROT) ? 2'b10 : 2'b01;
      end else begin
        // With zero or one request the request vector is already one-hot.
        gnt_o = req_i;
      end
    end
  end

endmodule

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl
//   Arbitrates two requesters (matrix loader, rotation unit) onto a register
//   file with a single write port and an asynchronous read port, and provides
//   a flush sequence that writes zero to every entry.
//   Ports:
//     clk, reset             : clock, synchronous active-high reset
//     req/req_we [1:0]       : per-requester request and write(1)/read(0)
//     req_addr0/1, req_wdata0/1 : per-requester address and write data
//     gnt [1:0]              : one-hot combinational grant
//     rsp_valid [1:0], rsp_data : registered read response, one cycle after grant
//     flush, busy, flush_done : flush request, flush in progress, completion pulse
//     rf_w_en/addr/data      : register-file write port
//     rf_r_addr, rf_r_data   : register-file read port
module rf_access_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [1:0]            req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [DATA_WIDTH-1:0] req_wdata0,
  input  logic [DATA_WIDTH-1:0] req_wdata1,
  output logic [1:0]            gnt,
  output logic [1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  flush,
  output logic                  busy,
  output logic                  flush_done,
  output logic                  rf_w_en,
  output logic [ADDR_WIDTH-1:0] rf_w_addr,
  output logic [DATA_WIDTH-1:0] rf_w_data,
  output logic [ADDR_WIDTH-1:0] rf_r_addr,
  input  logic [DATA_WIDTH-1:0] rf_r_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  busy_q, busy_d;
  logic                  flush_done_q, flush_done_d;

  logic                  in_flush;
  logic                  arb_en;
  logic                  any_gnt;
  logic                  sel;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  gnt_wr;
  logic                  gnt_rd;

  assign in_flush = (state_q == FLUSH);
  // The flush-accept cycle and reset both suppress grants.
  assign arb_en   = (state_q == IDLE) && !flush && !reset;

  rr_arb2 u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .en_i  (arb_en),
    .gnt_o (gnt)
  );

  assign any_gnt   = |gnt;
  assign sel       = gnt[REQ_ROT];
  assign sel_we    = req_we[sel];
  assign sel_addr  = sel ? req_addr1  : req_addr0;
  assign sel_wdata = sel ? req_wdata1 : req_wdata0;
  assign gnt_wr    = any_gnt && sel_we;
  assign gnt_rd    = any_gnt && !sel_we;

  assign rf_w_en   = !reset && (in_flush || gnt_wr);
  assign rf_w_addr = in_flush ? cnt_q : (gnt_wr ? sel_addr : '0);
  assign rf_w_data = in_flush ? '0    : (gnt_wr ? sel_wdata : '0);
  assign rf_r_addr = gnt_rd ? sel_addr : '0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    flush_done_d = 1'b0;
    rsp_valid_d  = gnt & ~req_we;
    rsp_data_d   = gnt_rd ? rf_r_data : rsp_data_q;
    // The requester just served loses priority to the other one.
    if (any_gnt) begin
      ptr_d = ~sel;
    end
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= REQ_LOADER;
      cnt_q        <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      busy_q       <= busy_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = busy_q;
  assign flush_done = flush_done_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb_rf_access_ctrl
//   Self-checking bench for rf_access_ctrl with a register-file stub and a
//   transaction-level reference model (ref_mem plus last-granted requester).
module tb_rf_access_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req, req_we;
  logic [1:0] req_addr0, req_addr1;
  logic [7:0] req_wdata0, req_wdata1;
  logic [1:0] gnt, rsp_valid;
  logic [7:0] rsp_data;
  logic       flush, busy, flush_done;
  logic       rf_w_en;
  logic [1:0] rf_w_addr, rf_r_addr;
  logic [7:0] rf_w_data, rf_r_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] rf_mem [4];
  logic [7:0] ref_mem [4];

  always #5 clk = ~clk;

  rf_access_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .flush(flush), .busy(busy), .flush_done(flush_done),
    .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
    .rf_r_addr(rf_r_addr), .rf_r_data(rf_r_data)
  );

  // Register-file stub: synchronous write, asynchronous read.
  always @(posedge clk) begin
    if (rf_w_en) rf_mem[rf_w_addr] <= rf_w_data;
  end
  assign rf_r_data = rf_mem[rf_r_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = 2'b00; req_we = 2'b00;
    req_addr0 = 2'd0; req_addr1 = 2'd0;
    req_wdata0 = 8'h00; req_wdata1 = 8'h00;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    req = 2'b11; req_we = 2'b11;
    #1;
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    total++; if (rf_w_en !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b exp=0", rf_w_en); end
    tick(); tick();
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rspv got=%b exp=00", rsp_valid); end
    total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL reset_rspd got=%h exp=00", rsp_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (flush_done !== 1'b0) begin bad++; $display("FAIL reset_fdone got=%b exp=0", flush_done); end
    idle_inputs();
    reset = 1'b0;
    tick();
    $display("txn reset checked");
  endtask

  task automatic test_write_read();
    do_reset();
    req = 2'b01; req_we = 2'b01; req_addr0 = 2'd2; req_wdata0 = 8'h5A;
    #1;
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL wr_gnt got=%b exp=01", gnt); end
    total++; if ({rf_w_en, rf_w_addr, rf_w_data} !== {1'b1, 2'd2, 8'h5A})
      begin bad++; $display("FAIL wr_port got=%b/%0d/%h exp=1/2/5a", rf_w_en, rf_w_addr, rf_w_data); end
    ref_mem[2] = 8'h5A;
    tick();
    $display("txn req0 write addr=2 data=5a");
    req_we = 2'b00;
    #1;
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rd_gnt got=%b exp=01", gnt); end
    total++; if (rf_r_addr !== 2'd2) begin bad++; $display("FAIL rd_addr got=%0d exp=2", rf_r_addr); end
    total++; if (rf_w_en !== 1'b0) begin bad++; $display("FAIL rd_wen got=%b exp=0", rf_w_en); end
    tick();
    idle_inputs();
    #1;
    total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL rd_rspv got=%b exp=01", rsp_valid); end
    total++; if (rsp_data !== 8'h5A) begin bad++; $display("FAIL rd_rspd got=%h exp=5a", rsp_data); end
    total++; if (rf_r_addr !== 2'd0) begin bad++; $display("FAIL idle_raddr got=%0d exp=0", rf_r_addr); end
    tick();
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rspv_drop got=%b exp=00", rsp_valid); end
    total++; if (rsp_data !== 8'h5A) begin bad++; $display("FAIL rspd_hold got=%h exp=5a", rsp_data); end
    $display("txn req0 read addr=2 data=%h", rsp_data);
  endtask

  task automatic test_contention();
    logic [1:0] exp_g, prev_g;
    logic [7:0] exp_d;
    do_reset();
    req = 2'b11; req_we = 2'b00; req_addr0 = 2'd1; req_addr1 = 2'd2;
    prev_g = 2'b00; exp_d = 8'h00;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      total++; if (gnt !== exp_g) begin bad++; $display("FAIL cont_gnt[%0d] got=%b exp=%b", i, gnt, exp_g); end
      total++; if (rsp_valid !== prev_g) begin bad++; $display("FAIL cont_rspv[%0d] got=%b exp=%b", i, rsp_valid, prev_g); end
      if (i > 0) begin
        total++; if (rsp_data !== exp_d) begin bad++; $display("FAIL cont_rspd[%0d] got=%h exp=%h", i, rsp_data, exp_d); end
      end
      prev_g = exp_g;
      exp_d  = ref_mem[(exp_g == 2'b01) ? 1 : 2];
      $display("txn contention cycle=%0d gnt=%b", i, gnt);
      tick();
    end
    idle_inputs();
    #1;
    total++; if (rsp_valid !== prev_g) begin bad++; $display("FAIL cont_rspv_last got=%b exp=%b", rsp_valid, prev_g); end
    total++; if (rsp_data !== exp_d) begin bad++; $display("FAIL cont_rspd_last got=%h exp=%h", rsp_data, exp_d); end
    tick();
  endtask

  task automatic test_flush();
    int done_cnt;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      req = 2'b01; req_we = 2'b01; req_addr0 = 2'(a); req_wdata0 = 8'hFF;
      #1;
      total++; if (gnt !== 2'b01) begin bad++; $display("FAIL fill_gnt[%0d] got=%b exp=01", a, gnt); end
      ref_mem[a] = 8'hFF;
      tick();
    end
    idle_inputs();
    flush = 1'b1;
    #1;
    total++; if (rf_w_en !== 1'b0) begin bad++; $display("FAIL flush_accept_wen got=%b exp=0", rf_w_en); end
    tick();
    flush = 1'b0;
    for (int a = 0; a < 4; a++) begin
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_busy[%0d] got=%b exp=1", a, busy); end
      total++; if ({rf_w_en, rf_w_addr, rf_w_data} !== {1'b1, 2'(a), 8'h00})
        begin bad++; $display("FAIL flush_wr[%0d] got=%b/%0d/%h exp=1/%0d/00", a, rf_w_en, rf_w_addr, rf_w_data, a); end
      total++; if (flush_done !== 1'b0) begin bad++; $display("FAIL flush_early_done[%0d] got=%b exp=0", a, flush_done); end
      ref_mem[a] = 8'h00;
      tick();
    end
    done_cnt = 0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy_end got=%b exp=0", busy); end
    for (int k = 0; k < 3; k++) begin
      if (flush_done === 1'b1) done_cnt++;
      tick();
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL flush_done_count got=%0d exp=1", done_cnt); end
    $display("txn flush complete pulses=%0d", done_cnt);
    for (int a = 0; a < 4; a++) begin
      req = 2'b10; req_we = 2'b00; req_addr1 = 2'(a);
      tick();
      idle_inputs();
      total++; if ({rsp_valid, rsp_data} !== {2'b10, ref_mem[a]})
        begin bad++; $display("FAIL post_flush_rd[%0d] got=%b/%h exp=10/%h", a, rsp_valid, rsp_data, ref_mem[a]); end
    end
    tick();
  endtask

  task automatic test_flush_vs_req();
    do_reset();
    req = 2'b10; req_we = 2'b00; req_addr1 = 2'd3; flush = 1'b1;
    #1;
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL fvr_accept_gnt got=%b exp=00", gnt); end
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (gnt !== 2'b00 || busy !== 1'b1)
        begin bad++; $display("FAIL fvr_flush_gnt[%0d] got=%b busy=%b exp=00 busy=1", i, gnt, busy); end
      tick();
    end
    #1;
    total++; if (flush_done !== 1'b1) begin bad++; $display("FAIL fvr_done got=%b exp=1", flush_done); end
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL fvr_done_gnt got=%b exp=10", gnt); end
    tick();
    idle_inputs();
    total++; if (rsp_valid !== 2'b10) begin bad++; $display("FAIL fvr_rspv got=%b exp=10", rsp_valid); end
    $display("txn flush vs req1 served after flush");
    tick();
  endtask

  task automatic test_reset_mid_flush();
    int done_cnt;
    do_reset();
    // Serve requester 0 so the pointer favours requester 1 before the reset.
    req = 2'b01; req_we = 2'b00;
    tick();
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    total++; if (rf_w_en !== 1'b0) begin bad++; $display("FAIL rmf_wen got=%b exp=0", rf_w_en); end
    tick();
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmf_busy got=%b exp=0", busy); end
    req = 2'b11; req_we = 2'b00;
    #1;
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rmf_ptr_gnt got=%b exp=01", gnt); end
    idle_inputs();
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (flush_done === 1'b1) done_cnt++;
      tick();
    end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL rmf_no_done got=%0d exp=0", done_cnt); end
    $display("txn reset mid flush aborted");
  endtask

  task automatic test_repeat_flush();
    int busy_cnt, done_cnt;
    do_reset();
    flush = 1'b1;
    tick();
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      flush = (i < 2);
      if (busy === 1'b1) busy_cnt++;
      if (flush_done === 1'b1) done_cnt++;
      tick();
    end
    total++; if (busy_cnt != 4) begin bad++; $display("FAIL rep_busy_cycles got=%0d exp=4", busy_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL rep_done_count got=%0d exp=1", done_cnt); end
    for (int a = 0; a < 4; a++) ref_mem[a] = 8'h00;
    $display("txn repeated flush busy=%0d done=%0d", busy_cnt, done_cnt);
  endtask

  task automatic test_random();
    logic [1:0] pv, pwe, exp_g, exp_rv;
    logic [1:0] pa [2];
    logic [7:0] pd [2];
    logic [7:0] exp_rd;
    int last, w;
    do_reset();
    last = 1; pv = 2'b00; pwe = 2'b00;
    pa[0] = 2'd0; pa[1] = 2'd0; pd[0] = 8'h00; pd[1] = 8'h00;
    exp_rv = 2'b00; exp_rd = 8'h00;
    for (int c = 0; c < 300; c++) begin
      total++; if (rsp_valid !== exp_rv) begin bad++; $display("FAIL rnd_rspv[%0d] got=%b exp=%b", c, rsp_valid, exp_rv); end
      total++; if (rsp_data !== exp_rd) begin bad++; $display("FAIL rnd_rspd[%0d] got=%h exp=%h", c, rsp_data, exp_rd); end
      for (int r = 0; r < 2; r++) begin
        if (!pv[r] && $urandom_range(2) != 0) begin
          pv[r]  = 1'b1;
          pwe[r] = 1'($urandom_range(1));
          pa[r]  = 2'($urandom_range(3));
          pd[r]  = 8'($urandom_range(255));
        end
      end
      req = pv; req_we = pwe;
      req_addr0 = pa[0]; req_addr1 = pa[1];
      req_wdata0 = pd[0]; req_wdata1 = pd[1];
      #1;
      if (pv == 2'b11) w = 1 - last;
      else if (pv[0])  w = 0;
      else if (pv[1])  w = 1;
      else             w = -1;
      exp_g = (w < 0) ? 2'b00 : (2'b01 << w);
      total++; if (gnt !== exp_g) begin bad++; $display("FAIL rnd_gnt[%0d] got=%b exp=%b", c, gnt, exp_g); end
      if (w >= 0 && pwe[w]) begin
        total++; if ({rf_w_en, rf_w_addr, rf_w_data} !== {1'b1, pa[w], pd[w]})
          begin bad++; $display("FAIL rnd_wr[%0d] got=%b/%0d/%h exp=1/%0d/%h", c, rf_w_en, rf_w_addr, rf_w_data, pa[w], pd[w]); end
        ref_mem[pa[w]] = pd[w];
        exp_rv = 2'b00;
        $display("txn rnd c=%0d req%0d write addr=%0d data=%h", c, w, pa[w], pd[w]);
      end else begin
        total++; if (rf_w_en !== 1'b0) begin bad++; $display("FAIL rnd_wen[%0d] got=%b exp=0", c, rf_w_en); end
      end
      if (w >= 0 && !pwe[w]) begin
        total++; if (rf_r_addr !== pa[w]) begin bad++; $display("FAIL rnd_raddr[%0d] got=%0d exp=%0d", c, rf_r_addr, pa[w]); end
        exp_rv = exp_g;
        exp_rd = ref_mem[pa[w]];
        $display("txn rnd c=%0d req%0d read addr=%0d data=%h", c, w, pa[w], exp_rd);
      end else begin
        total++; if (rf_r_addr !== 2'd0) begin bad++; $display("FAIL rnd_raddr0[%0d] got=%0d exp=0", c, rf_r_addr); end
        if (w < 0) exp_rv = 2'b00;
      end
      if (w >= 0) begin
        pv[w] = 1'b0;
        last  = w;
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    for (int a = 0; a < 4; a++) begin
      rf_mem[a]  = 8'h00;
      ref_mem[a] = 8'h00;
    end
    idle_inputs();
    reset = 1'b1;
    tick();
    test_reset();
    test_write_read();
    test_contention();
    test_flush();
    test_flush_vs_req();
    test_reset_mid_flush();
    test_repeat_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
